// File: rtl/nes_pad_reader_if.sv
// ---------------------------------------------------------------------------
// nes_pad_reader_if
//
// Groups the frame tick, the three NES pad pins and the decoded button bus
// that nes_pad_reader produces.
//
// Signals:
//   frame_rate     frame tick; a rising edge requests one poll of the pad
//   nes_data       serial data from the pad, active-low (0 = pressed)
//   nes_latch      latch strobe to the pad, active-high
//   nes_clk        shift clock to the pad, idles high
//   button_*       active-high, registered button levels
//   buttons_valid  one-clk pulse when a poll completes
//   busy           high while a poll is in progress
//
// Modports:
//   master  the pad reader (drives the pad strobes and the button bus)
//   slave   the surrounding system (frame tick, pad pin, button consumer)
// ---------------------------------------------------------------------------
interface nes_pad_reader_if;

    logic frame_rate;
    logic nes_data;
    logic nes_latch;
    logic nes_clk;

    logic button_a;
    logic button_b;
    logic button_select;
    logic button_start;
    logic button_up;
    logic button_down;
    logic button_left;
    logic button_right;

    logic buttons_valid;
    logic busy;

    modport master (
        input  frame_rate,
        input  nes_data,
        output nes_latch,
        output nes_clk,
        output button_a,
        output button_b,
        output button_select,
        output button_start,
        output button_up,
        output button_down,
        output button_left,
        output button_right,
        output buttons_valid,
        output busy
    );

    modport slave (
        output frame_rate,
        output nes_data,
        input  nes_latch,
        input  nes_clk,
        input  button_a,
        input  button_b,
        input  button_select,
        input  button_start,
        input  button_up,
        input  button_down,
        input  button_left,
        input  button_right,
        input  buttons_valid,
        input  busy
    );

endinterface

// File: rtl/nes_pad_reader.sv
// ---------------------------------------------------------------------------
// nes_pad_reader
//
// Polls a standard NES serial gamepad once per frame and presents eight
// active-high, registered button levels that stay stable until the next
// poll completes.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   pad    nes_pad_reader_if.master: frame_rate / nes_data in,
//          nes_latch / nes_clk / button_* / buttons_valid / busy out
//
// Parameters:
//   LATCH_CYCLES  clks nes_latch is held high (minimum 1)
//   HALF_CYCLES   clks per nes_clk half-period (minimum 3, so the 2-flop
//                 data synchronizer settles before the sample point)
//
// Optional feature (compile-time macro NES_PAD_DEBOUNCE_EN):
//   When defined, a new frame is only copied to the outputs if it equals the
//   previous raw frame, so a change needs two identical polls to appear.
//   buttons_valid still pulses on every poll.
//
// Bit order, bit 0 shifted first: A, B, select, start, up, down, left, right.
// Poll length from the clk after poll_start to buttons_valid:
//   LATCH_CYCLES + 16*HALF_CYCLES + 1 clks.
// ---------------------------------------------------------------------------
module nes_pad_reader #(
    parameter int unsigned LATCH_CYCLES = 300,
    parameter int unsigned HALF_CYCLES  = 150
) (
    input  logic             clk,
    input  logic             reset,
    nes_pad_reader_if.master pad
);

    // The phase counter only ever counts up to the longer of the two phases.
    localparam int unsigned MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned PHASE_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [2:0]         index_q, index_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         buttons_q, buttons_d;

    logic nes_latch_q, nes_latch_d;
    logic nes_clk_q, nes_clk_d;
    logic busy_q, busy_d;
    logic valid_q, valid_d;

    logic frame_meta_q, frame_sync_q, frame_prev_q;
    logic data_meta_q, data_sync_q;
    logic poll_start;

`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0] prev_q, prev_d;
`endif

    // Both asynchronous inputs go through two flops before use. frame_rate
    // gets a third flop so its rising edge can be detected as a single clk
    // poll request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_prev_q <= 1'b0;
            data_meta_q  <= 1'b0;
            data_sync_q  <= 1'b0;
        end else begin
            frame_meta_q <= pad.frame_rate;
            frame_sync_q <= frame_meta_q;
            frame_prev_q <= frame_sync_q;
            data_meta_q  <= pad.nes_data;
            data_sync_q  <= data_meta_q;
        end
    end

    assign poll_start = frame_sync_q & ~frame_prev_q;

    // State, counters, shift register and all outputs. The pad strobes,
    // busy and buttons_valid are registered from the next state so the pins
    // never see decode glitches and still line up exactly with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            index_q     <= 3'd0;
            shift_q     <= 8'h00;
            buttons_q   <= 8'h00;
            nes_latch_q <= 1'b0;
            nes_clk_q   <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            buttons_q   <= buttons_d;
            nes_latch_q <= nes_latch_d;
            nes_clk_q   <= nes_clk_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

`ifdef NES_PAD_DEBOUNCE_EN
    // Raw frame from the previous poll; starts as "all released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    // Next-state logic. A poll request is only honoured in IDLE, so requests
    // arriving while busy (including the DONE cycle) are simply dropped.
    // The button registers are loaded on the edge that enters DONE, so the
    // new levels are already present during the buttons_valid cycle.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        index_d   = index_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
`ifdef NES_PAD_DEBOUNCE_EN
        prev_d    = prev_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (poll_start) begin
                    state_d = ST_LATCH;
                    phase_d = '0;
                    shift_d = 8'h00;
                end
            end

            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = ST_HIGH;
                    phase_d = '0;
                    index_d = 3'd0;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_HIGH: begin
                // Sample on the last clk of the high half, when the pad's
                // data has had the whole half-period to pass the synchronizer.
                if (phase_q == HALF_LAST) begin
                    shift_d[index_q] = ~data_sync_q;
                    state_d          = ST_LOW;
                    phase_d          = '0;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_LOW: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (index_q == 3'd7) begin
                        state_d = ST_DONE;
`ifdef NES_PAD_DEBOUNCE_EN
                        if (shift_q == prev_q) begin
                            buttons_d = shift_q;
                        end
                        prev_d = shift_q;
`else
                        buttons_d = shift_q;
`endif
                    end else begin
                        index_d = index_q + 3'd1;
                        state_d = ST_HIGH;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        nes_latch_d = (state_d == ST_LATCH);
        nes_clk_d   = (state_d != ST_LOW);
        busy_d      = (state_d != ST_IDLE);
        valid_d     = (state_d == ST_DONE);
    end

    assign pad.nes_latch     = nes_latch_q;
    assign pad.nes_clk       = nes_clk_q;
    assign pad.busy          = busy_q;
    assign pad.buttons_valid = valid_q;

    assign pad.button_a      = buttons_q[0];
    assign pad.button_b      = buttons_q[1];
    assign pad.button_select = buttons_q[2];
    assign pad.button_start  = buttons_q[3];
    assign pad.button_up     = buttons_q[4];
    assign pad.button_down   = buttons_q[5];
    assign pad.button_left   = buttons_q[6];
    assign pad.button_right  = buttons_q[7];

endmodule
